// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives the master side; muldiv_unit implements the slave side.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output start, funct, data1, data2,
        input  result, hi, lo, busy, stall, done
    );

    modport slave (
        input  start, funct, data1, data2,
        output result, hi, lo, busy, stall, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit with private HI/LO registers, mthi/mtlo
// writes, mfhi/mflo reads, and a stall request while an operation is in flight.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               op_div, neg_q, neg_r, div_zero, done_q;
    logic               accept;

    logic               is_muldiv, is_move, is_signed, is_div;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    // Instruction decode
    assign is_muldiv = (bus.funct >= 6'h18) && (bus.funct <= 6'h1B);
    assign is_move   = (bus.funct >= 6'h10) && (bus.funct <= 6'h13);
    assign is_signed = ~bus.funct[0];
    assign is_div    = bus.funct[1];

    assign a_mag = (is_signed && bus.data1[WIDTH-1]) ? -bus.data1 : bus.data1;
    assign b_mag = (is_signed && bus.data2[WIDTH-1]) ? -bus.data2 : bus.data2;

    // Shift-add step: upper half accumulates, lower half holds the unconsumed multiplier bits
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: upper half is the partial remainder, lower half shifts dividend out / quotient in
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_ge ? (div_shift - {1'b0, opnd}) : div_shift;
    assign div_next  = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], div_ge};

    assign prod_fixed = neg_q ? -acc : acc;
    assign quo_fixed  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fixed  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && is_muldiv) begin
                    state_next = CALC;
                    accept     = 1'b1;
                end
            end
            CALC: begin
                if (count == LAST) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc      <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                        opnd     <= is_div ? b_mag : a_mag;
                        count    <= '0;
                        op_div   <= is_div;
                        neg_q    <= is_signed && (bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1]);
                        neg_r    <= is_signed && bus.data1[WIDTH-1];
                        div_zero <= (bus.data2 == '0);
                    end else if (bus.start && bus.funct == 6'h11) begin
                        hi_q <= bus.data1;
                    end else if (bus.start && bus.funct == 6'h13) begin
                        lo_q <= bus.data1;
                    end
                end
                CALC: begin
                    acc   <= op_div ? div_next : mul_next;
                    count <= count + CW'(1);
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (op_div) begin
                        // A zero divisor leaves the dividend magnitude as remainder, and the
                        // dividend-sign fix restores data1 exactly; only LO needs forcing.
                        lo_q <= div_zero ? '1 : quo_fixed;
                        hi_q <= rem_fixed;
                    end else begin
                        {hi_q, lo_q} <= prod_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.stall  = bus.busy && bus.start && (is_muldiv || is_move);
    assign bus.result = (bus.funct == 6'h10) ? hi_q : lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit for the EX stage, alongside the ALU and fed the same rs/rt operands and R-type funct field. Executes mult, multu, div and divu iteratively into private HI/LO registers. Services mthi/mtlo writes and mfhi/mflo reads, whose result goes to the writeback mux next to the ALU result. Drives a stall request so the hazard logic holds the pipeline while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  instruction valid in EX with opcode 0 (R-type); qualifies funct.
- funct  input  6  instruction funct field.
- data1  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source).
- data2  input  WIDTH  rt operand (divisor / multiplier).
- result  output  WIDTH  HI when funct=0x10 (mfhi), otherwise LO; combinational.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  iterative operation in flight.
- stall  output  1  busy & start & funct in {0x10–0x13, 0x18–0x1B}; combinational.
- done  output  1  one-cycle pulse when HI/LO receive a mult/div result.

## Operation
- Recognised funct codes:
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
  - 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo.
  - Other codes: no effect.
- States: IDLE, CALC, FIX.
- IDLE + start + mult/div funct:
  - Latch operand magnitudes (two's-complement absolute value for signed ops; raw for unsigned).
  - Latch result-sign flags. Clear count. Go to CALC.
- IDLE + start + mthi: HI <= data1. mtlo: LO <= data1. Stay IDLE.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC exits to FIX after WIDTH cycles (count = WIDTH-1).
- FIX:
  - Apply signs. Product is negated if the operand signs differ. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
  - Write {HI,LO}: HI=product[2W-1:W], LO=product[W-1:0]; for div, LO=quotient, HI=remainder.
  - Pulse done. Go to IDLE.
- Divide by zero (data2=0), signed or unsigned: LO=all ones, HI=data1 unchanged. Still takes the full latency.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- start while busy: ignored, no state change. stall asserts for move/mult/div functs.
- All arithmetic is modulo 2^WIDTH per half. No exceptions are raised.

## Timing
- Reset values: HI=0, LO=0, busy=0, done=0, state IDLE, count=0. result therefore reads 0.
- Reset during CALC or FIX aborts the operation: HI/LO become 0, no done pulse.
- Start accepted at edge E0. busy=1 from E0 to E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
- At E(WIDTH+1): HI/LO updated, busy=0, done=1 for exactly one cycle.
- A new start in that same done cycle is accepted. Back-to-back ops therefore issue every WIDTH+2 cycles.
- mthi/mtlo: HI/LO visible the cycle after the accepting edge.
- mfhi/mflo: result reflects current HI/LO combinationally. The bench checks that stall holds while busy.
- hi/lo outputs are stable throughout CALC; only FIX writes them.

## Test plan
- Reset, then mult data1=7, data2=0xFFFFFFFD (−3) -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, done one cycle, busy low.
- multu 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. mfhi then reads result=0xFFFFFFFE.
- div −7 (0xFFFFFFF9) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 100 / 0 -> LO=0xFFFFFFFF, HI=100. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Issue mult, then at cycle 5 assert start with mthi and with mult:
  - stall=1 both times.
  - HI/LO unchanged until the first op's done.
  - mthi 0x1234 after done -> HI=0x1234 next cycle.
- Start divu 50/7, assert reset at cycle 10 -> next cycle busy=0, HI=LO=0, and no done pulse afterward. A fresh divu 50/7 then gives LO=7, HI=1.
